// File: rtl/game_pkg.sv
// Shared game definitions: sequencer state encoding, map gamemode codes and screen geometry.
package game_pkg;

    // The state encoding doubles as the gamemode bus driven to the obstacle map.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    localparam logic [1:0] GM_IDLE  = 2'b00;
    localparam logic [1:0] GM_RUN   = 2'b01;
    localparam logic [1:0] GM_PAUSE = 2'b10;
    localparam logic [1:0] GM_OVER  = 2'b11;

    localparam int UPPER_BOUND  = 20;
    localparam int LOWER_BOUND  = 440;
    localparam int SCREEN_WIDTH = 640;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronised button level.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev_r;

    // Remember last cycle's level so a held button produces a single pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= btn;
        end
    end

    assign rise = btn & ~prev_r;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: IDLE/RUN/PAUSE/OVER control, score, level, scroll speed and high score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LEVEL_FRAMES = 600,
    parameter int MAX_LEVEL    = 7,
    parameter int BASE_SPEED   = 2,
    parameter int OVER_HOLD    = 90,
    parameter int SCORE_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               collision,
    output logic [1:0]         gamemode,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record,
    output logic [2:0]         level,
    output logic [3:0]         scroll_speed
);

    localparam int FRAME_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;
    localparam int HOLD_W  = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(LEVEL_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(OVER_HOLD);
    localparam logic [2:0]         LEVEL_MAX  = 3'(MAX_LEVEL);
    localparam logic [3:0]         SPEED_BASE = 4'(BASE_SPEED);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    if (BASE_SPEED + MAX_LEVEL > 15) begin : g_speed_chk
        $error("game_ctrl: BASE_SPEED + MAX_LEVEL does not fit the 4-bit scroll_speed");
    end
    if (MAX_LEVEL > 7) begin : g_level_chk
        $error("game_ctrl: MAX_LEVEL does not fit the 3-bit level");
    end

    game_state_t        state_r, state_nxt_s;
    logic [SCORE_W-1:0] score_r, score_nxt_s;
    logic [SCORE_W-1:0] high_r, high_nxt_s;
    logic               record_r, record_nxt_s;
    logic [2:0]         level_r, level_nxt_s;
    logic [3:0]         speed_r;
    logic [FRAME_W-1:0] frame_r, frame_nxt_s;
    logic [HOLD_W-1:0]  hold_r, hold_nxt_s;
    logic               start_rise_s;
    logic               pause_rise_s;

    btn_edge u_start_edge (.clk(clk), .rst(rst), .btn(btn_start), .rise(start_rise_s));
    btn_edge u_pause_edge (.clk(clk), .rst(rst), .btn(btn_pause), .rise(pause_rise_s));

    // Next-state and next-counter logic; collision outranks pause while running.
    always_comb begin
        state_nxt_s  = state_r;
        score_nxt_s  = score_r;
        high_nxt_s   = high_r;
        record_nxt_s = record_r;
        level_nxt_s  = level_r;
        frame_nxt_s  = frame_r;
        hold_nxt_s   = hold_r;
        case (state_r)
            IDLE: begin
                if (start_rise_s) begin
                    state_nxt_s  = RUN;
                    score_nxt_s  = {SCORE_W{1'b0}};
                    level_nxt_s  = 3'd0;
                    frame_nxt_s  = {FRAME_W{1'b0}};
                    record_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (collision) begin
                    state_nxt_s = OVER;
                    hold_nxt_s  = {HOLD_W{1'b0}};
                    if (score_r > high_r) begin
                        high_nxt_s   = score_r;
                        record_nxt_s = 1'b1;
                    end else begin
                        high_nxt_s = high_r;
                    end
                end else if (pause_rise_s) begin
                    state_nxt_s = PAUSE;
                end else begin
                    score_nxt_s = (score_r == SCORE_MAX) ? score_r : score_r + 1'b1;
                    if (frame_r == FRAME_LAST) begin
                        frame_nxt_s = {FRAME_W{1'b0}};
                        level_nxt_s = (level_r >= LEVEL_MAX) ? level_r : level_r + 3'd1;
                    end else begin
                        frame_nxt_s = frame_r + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (pause_rise_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            OVER: begin
                // A start before the hold expires is simply dropped, never queued.
                if ((hold_r == HOLD_MAX) && start_rise_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OVER;
                    hold_nxt_s  = (hold_r == HOLD_MAX) ? hold_r : hold_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; speed tracks the level being written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            score_r  <= {SCORE_W{1'b0}};
            high_r   <= {SCORE_W{1'b0}};
            record_r <= 1'b0;
            level_r  <= 3'd0;
            speed_r  <= SPEED_BASE;
            frame_r  <= {FRAME_W{1'b0}};
            hold_r   <= {HOLD_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            score_r  <= score_nxt_s;
            high_r   <= high_nxt_s;
            record_r <= record_nxt_s;
            level_r  <= level_nxt_s;
            speed_r  <= SPEED_BASE + {1'b0, level_nxt_s};
            frame_r  <= frame_nxt_s;
            hold_r   <= hold_nxt_s;
        end
    end

    assign gamemode     = state_r;
    assign score        = score_r;
    assign high_score   = high_r;
    assign new_record   = record_r;
    assign level        = level_r;
    assign scroll_speed = speed_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with small parameters and hand-computed expectations.
module tb_game_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_pause;
    logic        collision;
    logic [1:0]  gamemode;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        new_record;
    logic [2:0]  level;
    logic [3:0]  scroll_speed;

    int n_checks = 0;
    int n_errors = 0;

    game_ctrl #(
        .LEVEL_FRAMES(4),
        .MAX_LEVEL   (2),
        .BASE_SPEED  (2),
        .OVER_HOLD   (3),
        .SCORE_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .collision   (collision),
        .gamemode    (gamemode),
        .score       (score),
        .high_score  (high_score),
        .new_record  (new_record),
        .level       (level),
        .scroll_speed(scroll_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int gm, input int sc, input int hs,
                             input int nr, input int lv, input int sp);
        check({tag, ".gamemode"},     32'(gamemode),     32'(gm));
        check({tag, ".score"},        32'(score),        32'(sc));
        check({tag, ".high_score"},   32'(high_score),   32'(hs));
        check({tag, ".new_record"},   32'(new_record),   32'(nr));
        check({tag, ".level"},        32'(level),        32'(lv));
        check({tag, ".scroll_speed"}, 32'(scroll_speed), 32'(sp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_level(input int frames);
        if (frames >= 8) return 2;
        else if (frames >= 4) return 1;
        else return 0;
    endfunction

    initial begin
        rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; collision = 1'b0;
        tick(); tick();
        check_all("reset", 0, 0, 0, 0, 0, 2);
        rst = 1'b0;
        tick();
        check_all("idle", 0, 0, 0, 0, 0, 2);

        // Run A: start held, score climbs to 5, then collision and pause together.
        btn_start = 1'b1;
        tick();
        check_all("runA.enter", 1, 0, 0, 0, 0, 2);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_all("runA.frame", 1, i, 0, 0, exp_level(i), 2 + exp_level(i));
        end
        collision = 1'b1; btn_pause = 1'b1;
        tick();
        check_all("runA.over", 3, 5, 5, 1, 1, 3);
        btn_start = 1'b0; collision = 1'b0; btn_pause = 1'b0;

        // OVER hold: early start is dropped, later start after hold expiry returns to IDLE.
        tick();
        btn_start = 1'b1;
        tick();
        check("over.early_start", 32'(gamemode), 32'd3);
        btn_start = 1'b0;
        tick();
        check("over.hold", 32'(gamemode), 32'd3);
        btn_start = 1'b1;
        tick();
        check_all("over.to_idle", 0, 5, 5, 1, 1, 3);
        btn_start = 1'b0;
        tick();
        check("idle.stays", 32'(gamemode), 32'd0);

        // Run B: pause freezes everything, collision while paused is ignored, tie score.
        btn_start = 1'b1;
        tick();
        check_all("runB.enter", 1, 0, 5, 0, 0, 2);
        btn_start = 1'b0;
        tick(); tick(); tick();
        check_all("runB.f3", 1, 3, 5, 0, 0, 2);
        btn_pause = 1'b1;
        tick();
        check_all("runB.pause", 2, 3, 5, 0, 0, 2);
        collision = 1'b1;
        tick();
        check_all("runB.pause_col", 2, 3, 5, 0, 0, 2);
        tick();
        check("runB.pause_col2", 32'(gamemode), 32'd2);
        collision = 1'b0; btn_pause = 1'b0;
        tick();
        check("runB.paused", 32'(gamemode), 32'd2);
        btn_pause = 1'b1;
        tick();
        check_all("runB.resume", 1, 3, 5, 0, 0, 2);
        btn_pause = 1'b0;
        tick();
        check_all("runB.f4", 1, 4, 5, 0, 1, 3);
        tick();
        check_all("runB.f5", 1, 5, 5, 0, 1, 3);
        collision = 1'b1;
        tick();
        check_all("runB.tie", 3, 5, 5, 0, 1, 3);
        collision = 1'b0;
        tick(); tick(); tick();
        btn_start = 1'b1;
        tick();
        check("runB.to_idle", 32'(gamemode), 32'd0);
        btn_start = 1'b0;
        tick();

        // Run C: level saturation, then asynchronous reset between edges.
        btn_start = 1'b1;
        tick();
        check_all("runC.enter", 1, 0, 5, 0, 0, 2);
        btn_start = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            check_all("runC.frame", 1, i, 5, 0, exp_level(i), 2 + exp_level(i));
        end
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 2);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst", 32'(gamemode), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
